pixel_frame_sequencer: RTL and testbench

//  Frame-level controller for the LED-array pixel writer (writepixels). It holds a frame

---
 rtl/pixel_frame_if.sv | 23 ++
 rtl/pixel_frame_sequencer.sv | 137 +++++++++++++
 tb/tb_pixel_frame_sequencer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_frame_if.sv
// Host write port and pixel-writer handshake bundled for the frame sequencer.
// Slave is the sequencer side; master is the host/writer side.
interface pixel_frame_if #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = 6
);
  logic              i_wr_en;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [PIX_W-1:0]  i_wr_data;
  logic              i_pix_busy;
  logic [PIX_W-1:0]  o_pix_data;
  logic              o_pix_valid;

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_pix_busy,
    output o_pix_data, o_pix_valid
  );

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_pix_busy,
    input  o_pix_data, o_pix_valid
  );
endinterface

// File: rtl/pixel_frame_sequencer.sv
// Frame buffer plus frame-level FSM that streams one frame of pixels to the
// LED pixel writer per trigger, then holds a latch gap before the next frame.
module pixel_frame_sequencer #(
  parameter int unsigned NUM_PIXELS     = 64,
  parameter int unsigned PIX_W          = 8,
  parameter int unsigned ADDR_W         = 6,
  parameter int unsigned LATCH_CYCLES   = 1200,
  parameter int unsigned REFRESH_CYCLES = 1200000
) (
  input  logic             clk,
  input  logic             rst_n,
  pixel_frame_if.slave     bus,
  input  logic             i_start,
  input  logic             i_auto_en,
  output logic             o_busy,
  output logic             o_frame_done
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned AW1   = ADDR_W + 1;
  localparam int unsigned LAT_W = $clog2(LATCH_CYCLES + 1);
  localparam int unsigned REF_W = $clog2(REFRESH_CYCLES);

  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(LATCH_CYCLES - 1);
  localparam logic [REF_W-1:0]  REF_LAST = REF_W'(REFRESH_CYCLES - 1);
  localparam logic [AW1-1:0]    NUM_PIX  = AW1'(NUM_PIXELS);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SEND, S_HOLD, S_WAIT, S_LATCH
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [REF_W-1:0]  ref_q, ref_d;
  logic              pend_q, pend_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [PIX_W-1:0]  pix_q;
  logic              auto_tick_c;
  logic              trigger_c;

  logic [PIX_W-1:0]  mem [DEPTH];

  // Frame buffer: writes outside the frame are dropped; RAM itself is never reset.
  always_ff @(posedge clk) begin
    if (bus.i_wr_en && ({1'b0, bus.i_wr_addr} < NUM_PIX)) begin
      mem[bus.i_wr_addr] <= bus.i_wr_data;
    end
  end

  // Registered read doubles as the output data register, so data is stable through SEND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q <= '0;
    end else if (state_q == S_FETCH) begin
      pix_q <= mem[idx_q];
    end
  end

  always_comb begin
    auto_tick_c = i_auto_en && (ref_q == REF_LAST);
    trigger_c   = i_start | auto_tick_c;
    ref_d       = (!i_auto_en || auto_tick_c) ? '0 : ref_q + REF_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      lat_q   <= '0;
      ref_q   <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      ref_q   <= ref_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Outputs are derived from the next state so the registered copies line up with state_q.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lat_d   = lat_q;
    pend_d  = pend_q | trigger_c;
    unique case (state_q)
      S_IDLE: begin
        if (trigger_c || pend_q) begin
          state_d = S_FETCH;
          idx_d   = '0;
          pend_d  = 1'b0;
        end
      end
      S_FETCH: state_d = S_SEND;
      S_SEND: begin
        if (!bus.i_pix_busy) state_d = S_HOLD;
      end
      S_HOLD: state_d = S_WAIT;
      S_WAIT: begin
        if (!bus.i_pix_busy) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_LATCH;
            lat_d   = '0;
          end else begin
            state_d = S_FETCH;
            idx_d   = idx_q + ADDR_W'(1);
          end
        end
      end
      S_LATCH: begin
        if (lat_q == LAT_LAST) state_d = S_IDLE;
        else                   lat_d   = lat_q + LAT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    valid_d = (state_d == S_SEND);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_LATCH) && (lat_d == LAT_LAST);
  end

  assign bus.o_pix_data  = pix_q;
  assign bus.o_pix_valid = valid_q;
  assign o_busy          = busy_q;
  assign o_frame_done    = done_q;

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Self-checking bench for pixel_frame_sequencer: vector table, hand-written
// corner-case sequences, and randomized frames against a frame-buffer model.
`timescale 1ns/1ps
module tb_pixel_frame_sequencer;
  localparam int unsigned NP  = 4;
  localparam int unsigned PW  = 8;
  localparam int unsigned AW  = 3;
  localparam int unsigned LC  = 5;
  localparam int unsigned RC  = 50;
  localparam int          GAP = 4 + LC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_start = 1'b0;
  logic i_auto_en = 1'b0;
  logic o_busy, o_frame_done;

  pixel_frame_if #(.PIX_W(PW), .ADDR_W(AW)) bus ();

  pixel_frame_sequencer #(
    .NUM_PIXELS(NP), .PIX_W(PW), .ADDR_W(AW),
    .LATCH_CYCLES(LC), .REFRESH_CYCLES(RC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .i_start(i_start), .i_auto_en(i_auto_en),
    .o_busy(o_busy), .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  int          cyc = 0;
  int          done_cnt = 0;
  int          last_xfer_cyc = 0;
  logic [PW-1:0] got[$];
  int          rise_cyc[$];
  int          done_cyc[$];
  bit          xfer_seen = 0;
  bit          held_prev = 0;
  bit          busy_prev = 0;
  logic [PW-1:0] data_prev = '0;

  always @(negedge clk) begin
    cyc++;
    xfer_seen = bus.o_pix_valid && !bus.i_pix_busy;
    if (held_prev && bus.o_pix_valid) chk("data_stable", 32'(bus.o_pix_data), 32'(data_prev));
    held_prev = bus.o_pix_valid && bus.i_pix_busy;
    data_prev = bus.o_pix_data;
    if (xfer_seen) begin
      got.push_back(bus.o_pix_data);
      last_xfer_cyc = cyc;
    end
    if (o_busy && !busy_prev) rise_cyc.push_back(cyc);
    busy_prev = o_busy;
    if (o_frame_done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
    end
  end

  // Writer model: busy for 3 cycles starting the cycle after each transfer.
  int wcnt = 0;
  bit hold_busy = 0;
  bit rnd_mode = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst_n)         wcnt = 0;
    else if (xfer_seen) wcnt = 3;
    else if (wcnt > 0)  wcnt--;
    bus.i_pix_busy = hold_busy || (wcnt > 0) || (rnd_mode && ($urandom_range(0, 3) == 0));
  endtask

  task automatic wr(input int a, input int d);
    bus.i_wr_en   = 1'b1;
    bus.i_wr_addr = AW'(a);
    bus.i_wr_data = PW'(d);
    tick();
    bus.i_wr_en   = 1'b0;
  endtask

  task automatic pulse_start(output int s);
    s = cyc + 1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int base;
    int n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < 600) begin
      tick();
      n++;
    end
    chk({name, "_done_seen"}, 32'(done_cnt != base), 32'd1);
  endtask

  task automatic check_stream(input string name, input int ex[4]);
    chk({name, "_count"}, 32'(got.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < got.size()) chk($sformatf("%s_pix%0d", name, k), 32'(got[k]), 32'(ex[k]));
  endtask

  typedef struct {
    int wa[6];
    int wd[6];
    int ex[4];
  } vec_t;

  vec_t vecs[3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, d1, base, n, held;
    int e[4];
    int sh[4];

    vecs[0] = '{'{0, 1, 2, 3, 7, 5}, '{'h11, 'h22, 'h33, 'h44, 'hFF, 'hEE}, '{'h11, 'h22, 'h33, 'h44}};
    vecs[1] = '{'{3, 0, 0, 2, 1, 6}, '{'hA0, 'h5A, 'h5B, 'h00, 'hFF, 'h77}, '{'h5B, 'hFF, 'h00, 'hA0}};
    vecs[2] = '{'{1, 1, 2, 3, 0, 4}, '{'h01, 'h02, 'h80, 'h7F, 'hC3, 'h99}, '{'hC3, 'h02, 'h80, 'h7F}};

    bus.i_wr_en = 1'b0;
    bus.i_wr_addr = '0;
    bus.i_wr_data = '0;
    bus.i_pix_busy = 1'b0;

    // Reset values
    #2;
    chk("rst_valid", 32'(bus.o_pix_valid), 0);
    chk("rst_data", 32'(bus.o_pix_data), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_frame_done), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Vector table: writes (incl. out-of-range and overwrites) then one frame
    foreach (vecs[i]) begin
      for (int w = 0; w < 6; w++) wr(vecs[i].wa[w], vecs[i].wd[w]);
      got.delete();
      rise_cyc.delete();
      base = done_cnt;
      pulse_start(s);
      wait_done($sformatf("vec%0d", i));
      check_stream($sformatf("vec%0d", i), vecs[i].ex);
      chk($sformatf("vec%0d_start_lat", i), 32'(rise_cyc.size() > 0 ? rise_cyc[0] - s : -1), 32'd1);
      chk($sformatf("vec%0d_latch_gap", i), 32'(done_cyc[done_cyc.size()-1] - last_xfer_cyc), 32'(GAP));
      chk($sformatf("vec%0d_busy_after", i), 32'(o_busy), 0);
      chk($sformatf("vec%0d_one_done", i), 32'(done_cnt - base), 1);
      repeat (3) tick();
    end

    // Writer stalls SEND for 20 cycles; buffer is C3,02,80,7F
    got.delete();
    hold_busy = 1;
    pulse_start(s);
    n = 0;
    while (!bus.o_pix_valid && n < 10) begin tick(); n++; end
    held = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.o_pix_valid && bus.o_pix_data == 8'hC3) held++;
    end
    chk("stall_valid_held", 32'(held), 32'd20);
    chk("stall_no_xfer", 32'(got.size()), 0);
    hold_busy = 0;
    wait_done("stall");
    e = '{'hC3, 'h02, 'h80, 'h7F};
    check_stream("stall", e);
    repeat (3) tick();

    // Three mid-frame triggers collapse into one follow-on frame
    got.delete();
    rise_cyc.delete();
    base = done_cnt;
    pulse_start(s);
    repeat (5) tick();
    pulse_start(s);
    repeat (3) tick();
    pulse_start(s);
    repeat (3) tick();
    pulse_start(s);
    wait_done("pend_first");
    d1 = done_cyc[done_cyc.size()-1];
    wait_done("pend_second");
    chk("pend_frames_started", 32'(rise_cyc.size()), 2);
    if (rise_cyc.size() > 1) chk("pend_restart_cyc", 32'(rise_cyc[1] - d1), 2);
    repeat (80) tick();
    chk("pend_done_count", 32'(done_cnt - base), 2);
    chk("pend_xfer_count", 32'(got.size()), 8);

    // Auto-refresh every RC cycles while enabled
    rise_cyc.delete();
    base = done_cnt;
    i_auto_en = 1'b1;
    s = cyc + 1;
    repeat (180) tick();
    i_auto_en = 1'b0;
    repeat (120) tick();
    chk("auto_frames", 32'(rise_cyc.size()), 3);
    chk("auto_done", 32'(done_cnt - base), 3);
    for (int k = 0; k < 3; k++)
      if (k < rise_cyc.size()) chk($sformatf("auto_start%0d", k), 32'(rise_cyc[k] - s), 32'(RC * (k + 1)));

    // Host write to a pending pixel mid-frame, plus an out-of-range write
    got.delete();
    pulse_start(s);
    n = 0;
    while (!(got.size() == 1 && bus.o_pix_valid) && n < 50) begin tick(); n++; end
    chk("midwr_reached_pix1", 32'(got.size() == 1 && bus.o_pix_valid), 1);
    wr(2, 'hAA);
    wr(7, 'h55);
    wait_done("midwr");
    e = '{'hC3, 'h02, 'hAA, 'h7F};
    check_stream("midwr", e);
    repeat (2) tick();
    got.delete();
    pulse_start(s);
    wait_done("midwr_again");
    check_stream("midwr_again", e);
    repeat (2) tick();

    // Asynchronous reset while pixel 2 is offered
    got.delete();
    pulse_start(s);
    n = 0;
    while (!(got.size() == 2 && bus.o_pix_valid) && n < 50) begin tick(); n++; end
    chk("rstmid_reached_pix2", 32'(got.size() == 2 && bus.o_pix_valid), 1);
    base = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", 32'(bus.o_pix_valid), 0);
    chk("rstmid_data", 32'(bus.o_pix_data), 0);
    chk("rstmid_busy", 32'(o_busy), 0);
    chk("rstmid_done", 32'(o_frame_done), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (15) tick();
    chk("rstmid_no_done", 32'(done_cnt - base), 0);
    chk("rstmid_idle", 32'(o_busy), 0);
    got.delete();
    pulse_start(s);
    wait_done("rstmid_next");
    check_stream("rstmid_next", e);
    repeat (2) tick();

    // Randomized frames against a frame-buffer model, with random writer stalls
    for (int a = 0; a < 4; a++) begin
      sh[a] = int'($urandom_range(0, 255));
      wr(a, sh[a]);
    end
    for (int f = 0; f < 5; f++) begin
      for (int w = 0; w < 6; w++) begin
        int a, d;
        a = int'($urandom_range(0, 7));
        d = int'($urandom_range(0, 255));
        wr(a, d);
        if (a < NP) sh[a] = d;
      end
      got.delete();
      rnd_mode = 1;
      pulse_start(s);
      wait_done($sformatf("rand%0d", f));
      rnd_mode = 0;
      check_stream($sformatf("rand%0d", f), sh);
      repeat (2) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
